// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array result path.
package sa_pkg;

   localparam int SA_ADD_BW   = 32;
   localparam int SA_SIGN_BIT = SA_ADD_BW - 1;
   localparam int SA_COL_BW   = 8;

   typedef logic [SA_ADD_BW-1:0] bfp32_t;

   typedef struct packed {
      bfp32_t               data;
      logic [SA_COL_BW-1:0] col;
      logic                 last;
   } sa_word_t;

   // Clamp negative results to zero; the sign bit alone decides.
   function automatic bfp32_t sa_relu(input bfp32_t w);
      return w[SA_SIGN_BIT] ? '0 : w;
   endfunction

endpackage

// File: rtl/sa_col_fifo.sv
// Single-clock per-column deskew FIFO with occupancy count and synchronous flush.
module sa_col_fifo
   import sa_pkg::*;
#(
   parameter int W     = SA_ADD_BW,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sa_result_drain.sv
// Bottom-edge result collector: deskews column streams into rows and serializes them.
// Optional SA_DRAIN_RELU_EN zeroes negative words at the output mux.
//
// state | meaning
// IDLE  | no row held; waiting for every column FIFO to be non-empty
// EMIT  | row register presenting word col_q on the output stream
module sa_result_drain
   import sa_pkg::*;
#(
   parameter int N_COLS     = 4,
   parameter int ADD_BW     = SA_ADD_BW,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_BW     = 16,
   localparam int COL_W     = $clog2(N_COLS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic [CNT_BW-1:0]        i_rows,
   input  logic [N_COLS-1:0]        i_col_valid,
   input  logic [N_COLS*ADD_BW-1:0] i_col_data,
   output logic                     o_stall,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [ADD_BW-1:0]        o_data,
   output logic [COL_W-1:0]         o_col,
   output logic                     o_last,
   output logic                     o_done,
   output logic                     o_overflow
);

   localparam int FCW      = $clog2(FIFO_DEPTH) + 1;
   localparam int STALL_TH = FIFO_DEPTH - N_COLS;

   typedef enum logic {IDLE, EMIT} state_t;

   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ADD_BW-1:0]   row_q [N_COLS];
   logic [CNT_BW-1:0]   rows_q;
   logic [CNT_BW-1:0]   row_cnt_q;
   logic                done_seen_q;
   logic                pop;
   logic                row_done;
   logic                row_ready;
   logic                last;
   logic                hs;
   logic                final_row;
   logic [N_COLS-1:0]   push_v;
   logic [N_COLS-1:0]   fifo_full;
   logic [N_COLS-1:0]   fifo_empty;
   logic [ADD_BW-1:0]   fifo_dout [N_COLS];
   logic [FCW-1:0]      fifo_cnt  [N_COLS];
   bfp32_t              cur_word;

   // Strobes coinciding with a restart belong to the previous matrix.
   assign push_v = i_col_valid & {N_COLS{~i_start}};

   for (genvar c = 0; c < N_COLS; c++) begin : g_col
      sa_col_fifo #(.W(ADD_BW), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (i_start),
         .push  (push_v[c]),
         .pop   (pop),
         .din   (i_col_data[c*ADD_BW +: ADD_BW]),
         .dout  (fifo_dout[c]),
         .count (fifo_cnt[c]),
         .full  (fifo_full[c]),
         .empty (fifo_empty[c])
      );
   end

   assign row_ready = ~|fifo_empty;
   assign last      = (col_q == COL_W'(N_COLS - 1));
   assign o_valid   = (state_q == EMIT);
   assign hs        = o_valid & i_ready;
   assign o_col     = col_q;
   assign o_last    = o_valid & last;
   assign cur_word  = row_q[col_q];
   assign final_row = (rows_q != '0) && (row_cnt_q == rows_q - CNT_BW'(1)) && !done_seen_q;

`ifdef SA_DRAIN_RELU_EN
   assign o_data = sa_relu(cur_word);
`else
   assign o_data = cur_word;
`endif

   always_comb begin
      o_stall = 1'b0;
      for (int c = 0; c < N_COLS; c++) begin
         if (fifo_cnt[c] >= FCW'(STALL_TH)) o_stall = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      pop      = 1'b0;
      row_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (row_ready) begin
               pop     = 1'b1;
               col_d   = '0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (hs) begin
               if (!last) begin
                  col_d = col_q + COL_W'(1);
               end else begin
                  row_done = 1'b1;
                  col_d    = '0;
                  if (row_ready) pop = 1'b1;
                  else           state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (i_start) begin
         state_d  = IDLE;
         col_d    = '0;
         pop      = 1'b0;
         row_done = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         for (int c = 0; c < N_COLS; c++) row_q[c] <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         if (pop) begin
            for (int c = 0; c < N_COLS; c++) row_q[c] <= fifo_dout[c];
         end
      end
   end

   // Row counter freezes once the final row is signalled so o_done fires once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rows_q      <= '0;
         row_cnt_q   <= '0;
         done_seen_q <= 1'b0;
         o_done      <= 1'b0;
         o_overflow  <= 1'b0;
      end else if (i_start) begin
         rows_q      <= i_rows;
         row_cnt_q   <= '0;
         done_seen_q <= 1'b0;
         o_done      <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         o_done <= row_done & final_row;
         if (row_done) begin
            if (final_row)         done_seen_q <= 1'b1;
            else if (!done_seen_q) row_cnt_q   <= row_cnt_q + CNT_BW'(1);
         end
         if (|(push_v & fifo_full)) o_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain; honours SA_DRAIN_RELU_EN in its expected words.
module tb_sa_result_drain;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int CB = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           i_start;
   logic [CB-1:0]  i_rows;
   logic [N-1:0]   i_col_valid;
   logic [N*W-1:0] i_col_data;
   logic           o_stall;
   logic           o_valid;
   logic           i_ready;
   logic [W-1:0]   o_data;
   logic [1:0]     o_col;
   logic           o_last;
   logic           o_done;
   logic           o_overflow;

   sa_result_drain dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_rows      (i_rows),
      .i_col_valid (i_col_valid),
      .i_col_data  (i_col_data),
      .o_stall     (o_stall),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_data      (o_data),
      .o_col       (o_col),
      .o_last      (o_last),
      .o_done      (o_done),
      .o_overflow  (o_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] data;
      logic [1:0]   col;
      logic         last;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [W-1:0] tab [4][4];
   logic        stall_seen;

   function automatic logic [W-1:0] model(input logic [W-1:0] d);
`ifdef SA_DRAIN_RELU_EN
      return d[W-1] ? '0 : d;
`else
      return d;
`endif
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [CB-1:0] rows);
      i_start = 1'b1;
      i_rows  = rows;
      cyc();
      i_start = 1'b0;
   endtask

   // Column c of row r is driven on cycle r + c, as the array delivers it.
   task automatic stream_rows(input int n);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < N; c++)
            sb.push_back('{model(tab[r][c]), 2'(c), (c == N - 1)});
      for (int t = 0; t < n + N - 1; t++) begin
         for (int c = 0; c < N; c++) begin
            if (t - c >= 0 && t - c < n) begin
               i_col_valid[c]           = 1'b1;
               i_col_data[c*W +: W]     = tab[t-c][c];
            end else begin
               i_col_valid[c] = 1'b0;
            end
         end
         cyc();
      end
      i_col_valid = '0;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         cyc();
         guard++;
      end
      check(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got %h col %0d, expected no word", o_data, o_col);
            end else begin
               e = sb.pop_front();
               check("word_data", o_data, e.data);
               check("word_col", 32'(o_col), 32'(e.col));
               check("word_last", 32'(o_last), 32'(e.last));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL timeout: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst         = 1'b0;
      i_start     = 1'b0;
      i_rows      = '0;
      i_col_valid = '0;
      i_col_data  = '0;
      i_ready     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(o_valid), 0);
      check("rst_data", o_data, 0);
      check("rst_col", 32'(o_col), 0);
      check("rst_last", 32'(o_last), 0);
      check("rst_done", 32'(o_done), 0);
      check("rst_stall", 32'(o_stall), 0);
      check("rst_overflow", 32'(o_overflow), 0);
      rst = 1'b1;
      cyc();
      pulse_start(0);

      // Reset in the middle of a row: the two pushed columns must vanish.
      i_col_valid = 4'b0011;
      i_col_data  = {32'h0, 32'h0, 32'hDEAD0001, 32'hDEAD0000};
      cyc();
      i_col_valid = '0;
      #2 rst = 1'b0;
      #1;
      check("midrow_rst_valid", 32'(o_valid), 0);
      check("midrow_rst_data", o_data, 0);
      check("midrow_rst_stall", 32'(o_stall), 0);
      cyc();
      rst = 1'b1;
      cyc();
      tab[0] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      stream_rows(1);
      drain("drain_after_reset");

      // Skewed row with latency check.
      tab[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
      stream_rows(1);
      check("latency_not_early", 32'(o_valid), 0);
      cyc();
      check("latency_valid", 32'(o_valid), 1);
      check("latency_first_col", 32'(o_col), 0);
      check("latency_first_data", o_data, model(32'h3F800000));
      drain("drain_skew");

      // Three rows back to back with o_done.
      pulse_start(3);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < N; c++)
            tab[r][c] = 32'h1000_0000 + 32'(r * 16 + c);
      fork
         stream_rows(3);
         begin
            int guard = 0;
            @(negedge clk);
            while (!o_valid && guard < 20) begin
               @(negedge clk);
               guard++;
            end
            check("rows3_first_valid", 32'(o_valid), 1);
            for (int k = 0; k < 12; k++) begin
               check("rows3_no_gap", 32'(o_valid), 1);
               check("rows3_done_early", 32'(o_done), 0);
               @(negedge clk);
            end
            check("rows3_done_pulse", 32'(o_done), 1);
            check("rows3_valid_after", 32'(o_valid), 0);
            @(negedge clk);
            check("rows3_done_one_cycle", 32'(o_done), 0);
         end
      join
      drain("drain_rows3");

      // Backpressure while four rows arrive.
      pulse_start(0);
      i_ready    = 1'b0;
      stall_seen = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < N; c++)
            tab[r][c] = 32'h2000_0000 + 32'(r * 16 + c);
      fork
         stream_rows(4);
         repeat (7) begin
            @(negedge clk);
            if (o_stall) stall_seen = 1'b1;
         end
      join
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("bp_hold_valid", 32'(o_valid), 1);
         check("bp_hold_data", o_data, model(32'h2000_0000));
      end
      check("bp_stall_seen", 32'(stall_seen), 1);
      check("bp_no_overflow", 32'(o_overflow), 0);
      i_ready = 1'b1;
      drain("drain_backpressure");

      // Overflow on column 0, cleared by restart.
      pulse_start(0);
      for (int k = 0; k < 8; k++) begin
         i_col_valid = 4'b0001;
         i_col_data  = {96'h0, 32'h5000_0000 + 32'(k)};
         cyc();
      end
      check("ovf_not_yet", 32'(o_overflow), 0);
      check("ovf_stall", 32'(o_stall), 1);
      cyc();
      i_col_valid = '0;
      check("ovf_set", 32'(o_overflow), 1);
      check("ovf_no_word", 32'(o_valid), 0);
      pulse_start(0);
      check("ovf_cleared", 32'(o_overflow), 0);
      check("ovf_stall_cleared", 32'(o_stall), 0);

      // Sign-bit handling (raw by default, clamped when ReLU is enabled).
      tab[0] = '{32'hC0000000, 32'h40000000, 32'h80000001, 32'h7FFFFFFF};
      stream_rows(1);
      drain("drain_relu");

      repeat (3) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
